// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types for the GPR write-back arbiter.
// State encoding and starve counter width.
package gpr_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FORCE
  } wb_arb_state_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Write-back port bundle: pipeline and long-latency sources in,
// GPR write port and pending-rd hazard info out.
interface gpr_wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            pipe_valid;
  logic            pipe_ready;
  logic            pipe_wen;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            gpr_wen;
  logic [4:0]      gpr_rd;
  logic [XLEN-1:0] gpr_data;
  logic            pend_valid;
  logic [4:0]      pend_rd;

  modport master (
    output pipe_valid, pipe_wen, pipe_rd, pipe_data,
    output lu_valid, lu_rd, lu_data,
    input  pipe_ready, lu_ready,
    input  gpr_wen, gpr_rd, gpr_data,
    input  pend_valid, pend_rd
  );

  modport slave (
    input  pipe_valid, pipe_wen, pipe_rd, pipe_data,
    input  lu_valid, lu_rd, lu_data,
    output pipe_ready, lu_ready,
    output gpr_wen, gpr_rd, gpr_data,
    output pend_valid, pend_rd
  );
endinterface

// File: rtl/gpr_wb_arbiter_hold_buf.sv
// One-entry holding register for a long-latency result.
// Push wins over pop so a drain and a new accept can share an edge.
module wb_hold_buf #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_data,
  output logic            o_valid,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_data
);

  logic            r_valid;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_rd    <= i_rd;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end
  end

  assign o_valid = r_valid;
  assign o_rd    = r_rd;
  assign o_data  = r_data;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: pipeline first, long-latency result
// buffered and drained on idle port cycles or after starvation.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 64
) (
  input  logic             clk,
  input  logic             rst,
  gpr_wb_arbiter_if.slave  bus
);

  wb_arb_state_t       r_state;
  logic [STARVE_W-1:0] r_cnt;

  logic            w_pend_valid;
  logic [4:0]      w_pend_rd;
  logic [XLEN-1:0] w_pend_data;
  logic            w_pipe_w;
  logic            w_drain;
  logic            w_lu_ready;
  logic            w_push;

  localparam logic [STARVE_W-1:0] CntLast =
    STARVE_W'(STARVE_MAX - 1);

  // Only a real rd write (non-x0) competes for the port.
  assign w_pipe_w = bus.pipe_valid && bus.pipe_wen
                 && (bus.pipe_rd != 5'd0);
  assign w_drain  = (r_state == FORCE)
                 || ((r_state == HOLD) && !w_pipe_w);
  assign w_lu_ready = !w_pend_valid || w_drain;
  assign w_push     = bus.lu_valid && w_lu_ready
                   && (bus.lu_rd != 5'd0);

  assign bus.pipe_ready = (r_state != FORCE);
  assign bus.lu_ready   = w_lu_ready;
  assign bus.pend_valid = w_pend_valid;
  assign bus.pend_rd    = w_pend_rd;

  wb_hold_buf #(
    .XLEN(XLEN)
  ) u_hold_buf (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_drain),
    .i_rd   (bus.lu_rd),
    .i_data (bus.lu_data),
    .o_valid(w_pend_valid),
    .o_rd   (w_pend_rd),
    .o_data (w_pend_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_push) r_state <= HOLD;
        end
        HOLD: begin
          if (w_drain) begin
            r_cnt   <= '0;
            r_state <= w_push ? HOLD : IDLE;
          end else if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_state <= FORCE;
          end else begin
            r_cnt <= r_cnt + STARVE_W'(1);
          end
        end
        FORCE: begin
          r_cnt   <= '0;
          r_state <= w_push ? HOLD : IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.gpr_wen  = 1'b0;
    bus.gpr_rd   = '0;
    bus.gpr_data = '0;
    if (w_drain) begin
      bus.gpr_wen  = 1'b1;
      bus.gpr_rd   = w_pend_rd;
      bus.gpr_data = w_pend_data;
    end else if (w_pipe_w && bus.pipe_ready) begin
      bus.gpr_wen  = 1'b1;
      bus.gpr_rd   = bus.pipe_rd;
      bus.gpr_data = bus.pipe_data;
    end
  end

endmodule
